interrupt_request_unit: RTL

//  Producer of interrupts_signal: latches external IRQs, masks and prioritises them, then picks a

---
 rtl/interrupt_request_unit_pkg.sv | 44 ++++
 rtl/irq_priority_encoder.sv | 22 ++
 rtl/interrupt_request_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/interrupt_request_unit_pkg.sv
// Shared opcode and interrupt-state encodings for the interrupt request unit and its users.
// Opcode macros are guarded so an existing global defines file may provide them first.
`ifndef OPCODE_BEQ
`define OPCODE_BEQ 6'b000100
`endif
`ifndef OPCODE_BNE
`define OPCODE_BNE 6'b000101
`endif
`ifndef OPCODE_LW
`define OPCODE_LW 6'b100011
`endif
`ifndef OPCODE_ERET
`define OPCODE_ERET 6'b010000
`endif
`ifndef IRS_IDLE
`define IRS_IDLE 2'd0
`define IRS_FLUSH 2'd1
`define IRS_HANDLER 2'd2
`define IRS_RETURN 2'd3
`endif

package interrupt_request_unit_pkg;

    localparam logic [5:0] OPC_BEQ  = `OPCODE_BEQ;
    localparam logic [5:0] OPC_BNE  = `OPCODE_BNE;
    localparam logic [5:0] OPC_ERET = `OPCODE_ERET;

    typedef enum logic [1:0] {
        IRS_IDLE    = `IRS_IDLE,
        IRS_FLUSH   = `IRS_FLUSH,
        IRS_HANDLER = `IRS_HANDLER,
        IRS_RETURN  = `IRS_RETURN
    } irs_state_e;

    // A control-flow instruction at step4 would have its redirect lost by a flush.
    function automatic logic step4_is_unsafe(input logic valid, input logic [5:0] opcode);
        return valid && ((opcode == OPC_BEQ) || (opcode == OPC_BNE) || (opcode == OPC_ERET));
    endfunction

    function automatic logic step4_is_eret(input logic valid, input logic [5:0] opcode);
        return valid && (opcode == OPC_ERET);
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
module irq_priority_encoder #(
    parameter int NUM_IRQ = 4,
    localparam int IDX_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               any,
    output logic [IDX_W-1:0]   index
);

    // Scanning downwards lets the lowest set index overwrite any higher one.
    always_comb begin
        any   = |req;
        index = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_request_unit.sv
// Latches, masks and prioritises external IRQs, takes them precisely at step4 and handles ERET.
// One interrupt is serviced at a time; flush/redirect pulses last exactly one cycle.
module interrupt_request_unit
    import interrupt_request_unit_pkg::*;
#(
    parameter int               NUM_IRQ       = 4,
    parameter int               PC_W          = 32,
    parameter logic [PC_W-1:0]  VECTOR_BASE   = 32'h0000_0180,
    parameter logic [PC_W-1:0]  VECTOR_STRIDE = 32'h0000_0010,
    localparam int              CAUSE_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               step4_valid,
    input  logic [5:0]         opcode_step4,
    input  logic [PC_W-1:0]    pc_step3,
    input  logic               load_hazard_signal,
    output logic               interrupts_signal,
    output logic               pc_redirect_valid,
    output logic [PC_W-1:0]    pc_redirect,
    output logic [PC_W-1:0]    epc,
    output logic [CAUSE_W-1:0] cause,
    output logic               in_handler,
    output logic [NUM_IRQ-1:0] irq_mask
);

    irs_state_e         state;
    irs_state_e         state_next;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] pending_next;
    logic [NUM_IRQ-1:0] clr_bit;
    logic               pend_any;
    logic [CAUSE_W-1:0] pend_index;
    logic               take;
    logic               eret_at4;
    logic [PC_W-1:0]    vector_addr;

    // A take flushes the stalled instruction too, so the load stall never holds it off.
    logic unused_load_hazard;
    assign unused_load_hazard = load_hazard_signal;

    irq_priority_encoder #(
        .NUM_IRQ(NUM_IRQ)
    ) u_prio (
        .req  (pending),
        .any  (pend_any),
        .index(pend_index)
    );

    assign take     = (state == IRS_IDLE) && pend_any && !step4_is_unsafe(step4_valid, opcode_step4);
    assign eret_at4 = step4_is_eret(step4_valid, opcode_step4);
    assign clr_bit  = take ? (NUM_IRQ'(1) << pend_index) : '0;

    // Same-cycle irq is gated by the old mask; a mask write then drops anything newly disabled.
    always_comb begin
        pending_next = (pending | (irq & irq_mask)) & ~clr_bit;
        if (mask_we) begin
            pending_next = pending_next & mask_wdata;
        end
    end

    // Truncation to PC_W gives the modulo-2^PC_W vector arithmetic.
    assign vector_addr = VECTOR_BASE + (PC_W'(cause) * VECTOR_STRIDE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IRS_IDLE;
            pending  <= '0;
            irq_mask <= '0;
            epc      <= '0;
            cause    <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            if (mask_we) begin
                irq_mask <= mask_wdata;
            end
            if (take) begin
                epc   <= pc_step3;
                cause <= pend_index;
            end
        end
    end

    always_comb begin
        state_next        = state;
        interrupts_signal = 1'b0;
        pc_redirect_valid = 1'b0;
        pc_redirect       = '0;
        in_handler        = 1'b0;
        unique case (state)
            IRS_IDLE: begin
                if (take) begin
                    state_next = IRS_FLUSH;
                end
            end
            IRS_FLUSH: begin
                interrupts_signal = 1'b1;
                pc_redirect_valid = 1'b1;
                pc_redirect       = vector_addr;
                in_handler        = 1'b1;
                state_next        = IRS_HANDLER;
            end
            IRS_HANDLER: begin
                in_handler = 1'b1;
                if (eret_at4) begin
                    state_next = IRS_RETURN;
                end
            end
            IRS_RETURN: begin
                interrupts_signal = 1'b1;
                pc_redirect_valid = 1'b1;
                pc_redirect       = epc;
                in_handler        = 1'b1;
                state_next        = IRS_IDLE;
            end
            default: begin
                state_next = IRS_IDLE;
            end
        endcase
    end

endmodule
